// File: rtl/fp8_pkg.sv
// Shared E4M3 / int8 constants and the unpacked FP8 field layout.
package fp8_pkg;

  localparam int unsigned     E4M3_BIAS = 7;
  localparam logic [6:0]      E4M3_NAN  = 7'h7F;
  localparam logic signed [7:0] INT8_MAX = 8'sd127;
  localparam logic signed [7:0] INT8_MIN = -8'sd128;

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [2:0] man;
  } e4m3_t;

endpackage

// File: rtl/fp8_to_int8_lane_decode.sv
// Combinational E4M3 unpack: fields, NaN/subnormal class and signed shift (e-10).
module fp8_decode
  import fp8_pkg::*;
(
  input  logic              [7:0] data,
  output e4m3_t                   fields,
  output logic                    is_nan,
  output logic                    is_sub,
  output logic signed       [4:0] shift
);

  always_comb begin
    fields = e4m3_t'(data);
    is_nan = (data[6:0] == E4M3_NAN);
    is_sub = (fields.exp == 4'd0);
    // Integer point sits 3 bits into {1,m}, so the shift is e - bias - 3.
    shift  = $signed({1'b0, fields.exp}) - 5'(E4M3_BIAS + 3);
  end

endmodule

// File: rtl/fp8_to_int8_lane.sv
// FP8 (E4M3) to int8 dequantize lane: 2-stage valid/ready pipeline with
// round-to-nearest-even, saturation and sticky NaN/saturation status.
module fp8_to_int8_lane
  import fp8_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat,
  output logic       out_nan,
  input  logic       clear_flags,
  output logic       sticky_sat,
  output logic       sticky_nan
);

  e4m3_t              dec_fields;
  logic               dec_is_nan;
  logic               dec_is_sub;
  logic signed  [4:0] dec_shift;

  fp8_decode u_decode (
    .data   (in_data),
    .fields (dec_fields),
    .is_nan (dec_is_nan),
    .is_sub (dec_is_sub),
    .shift  (dec_shift)
  );

  logic               s1_valid;
  logic               s1_sign;
  logic               s1_nan;
  logic               s1_zero;
  logic         [3:0] s1_sig;
  logic signed  [4:0] s1_shift;

  logic               s2_valid;
  logic         [7:0] s2_data;
  logic               s2_sat;
  logic               s2_nan;

  logic               s2_empty_or_draining;
  logic               in_fire;

  assign s2_empty_or_draining = !s2_valid || out_ready;
  assign in_ready  = enable && !reset && (!s1_valid || s2_empty_or_draining);
  assign in_fire   = in_valid && in_ready;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_sat   = s2_sat;
  assign out_nan   = s2_nan;

  // S2 round/saturate datapath, fed from the S1 registers.
  logic         [8:0] mag;
  logic         [7:0] frac;
  logic         [4:0] rshift;
  logic               round_up;
  logic         [7:0] res;
  logic               res_sat;

  always_comb begin
    mag      = '0;
    frac     = '0;
    rshift   = 5'(-s1_shift);
    round_up = 1'b0;
    res      = '0;
    res_sat  = 1'b0;

    if (!s1_shift[4]) begin
      mag = {5'b0, s1_sig} << s1_shift[2:0];
    end else begin
      // frac holds 4 integer and 4 fraction bits; only shifts of 1..4 reach here
      // as non-zero results.
      frac     = {s1_sig, 4'b0} >> rshift[2:0];
      round_up = frac[3] && ((|frac[2:0]) || frac[4]);
      mag      = {5'b0, frac[7:4]} + {8'b0, round_up};
    end

    if (s1_nan || s1_zero) begin
      res = '0;
    end else if (!s1_sign) begin
      if (mag > 9'd127) begin
        res     = INT8_MAX;
        res_sat = 1'b1;
      end else begin
        res = mag[7:0];
      end
    end else begin
      if (mag > 9'd128) begin
        res     = INT8_MIN;
        res_sat = 1'b1;
      end else begin
        res = -mag[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_nan   <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sig   <= '0;
      s1_shift <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sat   <= 1'b0;
      s2_nan   <= 1'b0;
    end else if (enable) begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_sign  <= dec_fields.sign;
        s1_nan   <= dec_is_nan;
        s1_zero  <= dec_is_sub || (dec_shift < -5'sd4);
        s1_sig   <= {|dec_fields.exp, dec_fields.man};
        s1_shift <= dec_shift;
      end else if (s2_empty_or_draining) begin
        s1_valid <= 1'b0;
      end

      if (s2_empty_or_draining) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= res;
          s2_sat  <= res_sat;
          s2_nan  <= s1_nan;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_flags) begin
      sticky_sat <= 1'b0;
      sticky_nan <= 1'b0;
    end else if (enable && s2_valid && out_ready) begin
      sticky_sat <= sticky_sat | s2_sat;
      sticky_nan <= sticky_nan | s2_nan;
    end
  end

endmodule

// File: tb/tb_fp8_to_int8_lane.sv
// Directed self-checking bench for fp8_to_int8_lane.
module tb_fp8_to_int8_lane;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;
  logic       out_nan;
  logic       clear_flags;
  logic       sticky_sat;
  logic       sticky_nan;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  fp8_to_int8_lane dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_nan     (out_nan),
    .clear_flags (clear_flags),
    .sticky_sat  (sticky_sat),
    .sticky_nan  (sticky_nan)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one byte with out_ready high, wait for its result and check it.
  task automatic send_one(input string tag, input logic [7:0] d, input logic [7:0] exp_d,
                          input logic exp_sat, input logic exp_nan);
    int unsigned w;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    w = 0;
    while (!in_ready && w < 10) begin
      tick();
      w++;
    end
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      tick();
      w++;
    end
    if (!out_valid) begin
      check({tag, "_timeout"}, 16'(out_valid), 16'd1);
    end else begin
      check({tag, "_data"}, 16'(out_data), 16'(exp_d));
      check({tag, "_sat"},  16'(out_sat),  16'(exp_sat));
      check({tag, "_nan"},  16'(out_nan),  16'(exp_nan));
    end
    tick();
  endtask

  logic [7:0] bp_vec [4] = '{8'h38, 8'h40, 8'h44, 8'h48};
  logic [7:0] bp_exp [4] = '{8'd1, 8'd2, 8'd3, 8'd4};

  initial begin
    int unsigned idx;
    int unsigned n_out;
    logic        gap;
    logic        fire;

    reset       = 1'b1;
    enable      = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b1;
    clear_flags = 1'b0;
    tick();
    tick();
    check("rst_out_valid",  16'(out_valid),  16'd0);
    check("rst_out_data",   16'(out_data),   16'd0);
    check("rst_out_flags",  16'({out_sat, out_nan}), 16'd0);
    check("rst_sticky",     16'({sticky_sat, sticky_nan}), 16'd0);
    check("rst_in_ready",   16'(in_ready),   16'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 16'(in_ready), 16'd1);

    // Back-to-back stream, latency two cycles from presentation.
    in_valid = 1'b1;
    in_data  = 8'h38;
    tick();
    in_data = 8'h40;
    tick();
    check("str0_valid", 16'(out_valid), 16'd1);
    check("str0_data",  16'(out_data),  16'd1);
    in_data = 8'h44;
    tick();
    check("str1_data",  16'(out_data),  16'd2);
    in_data = 8'h48;
    tick();
    check("str2_data",  16'(out_data),  16'd3);
    in_valid = 1'b0;
    tick();
    check("str3_data",  16'(out_data),  16'd4);
    check("str3_flags", 16'({out_sat, out_nan}), 16'd0);
    tick();
    check("str_drained", 16'(out_valid), 16'd0);

    // Rounding
    send_one("r_0p5",  8'h30, 8'h00, 1'b0, 1'b0);
    send_one("r_0p75", 8'h34, 8'h01, 1'b0, 1'b0);
    send_one("r_1p5",  8'h3C, 8'h02, 1'b0, 1'b0);
    send_one("r_2p5",  8'h42, 8'h02, 1'b0, 1'b0);
    send_one("r_m1p5", 8'hBC, 8'hFE, 1'b0, 1'b0);
    send_one("r_sub",  8'h05, 8'h00, 1'b0, 1'b0);
    check("r_sticky", 16'({sticky_sat, sticky_nan}), 16'd0);

    // Saturation
    send_one("s_224",  8'h76, 8'h7F, 1'b1, 1'b0);
    send_one("s_m128", 8'hF0, 8'h80, 1'b0, 1'b0);
    send_one("s_m144", 8'hF1, 8'h80, 1'b1, 1'b0);
    check("s_sticky_sat", 16'(sticky_sat), 16'd1);
    check("s_sticky_nan", 16'(sticky_nan), 16'd0);

    // NaN and clear
    send_one("n_pos", 8'h7F, 8'h00, 1'b0, 1'b1);
    send_one("n_neg", 8'hFF, 8'h00, 1'b0, 1'b1);
    check("n_sticky_nan", 16'(sticky_nan), 16'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("clr_sticky", 16'({sticky_sat, sticky_nan}), 16'd0);

    // Backpressure: out_ready low for 5 cycles while offering 4 inputs.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) in_data = bp_vec[idx];
      #1;
      if (out_valid) check("bp_hold_data", 16'(out_data), 16'd1);
      fire = in_valid && in_ready;
      tick();
      if (fire) idx++;
    end
    check("bp_accepts",  16'(idx),      16'd2);
    #1;
    check("bp_in_ready", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    n_out = 0;
    gap   = 1'b0;
    for (int c = 0; c < 12 && n_out < 4; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) in_data = bp_vec[idx];
      #1;
      if (out_valid) begin
        check("bp_order", 16'(out_data), 16'(bp_exp[n_out]));
        n_out++;
      end else if (n_out > 0) begin
        gap = 1'b1;
      end
      fire = in_valid && in_ready;
      tick();
      if (fire) idx++;
    end
    in_valid = 1'b0;
    check("bp_count", 16'(n_out), 16'd4);
    check("bp_gap",   16'(gap),   16'd0);
    check("bp_after", 16'(out_valid), 16'd0);

    // Enable low mid-stream, then reset with both stages full.
    send_one("e_sat", 8'h76, 8'h7F, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h44;
    tick();
    in_data = 8'h48;
    tick();
    check("e_full_valid", 16'(out_valid), 16'd1);
    check("e_full_data",  16'(out_data),  16'd3);
    enable    = 1'b0;
    out_ready = 1'b1;
    in_data   = 8'h38;
    for (int c = 0; c < 3; c++) begin
      clear_flags = (c == 1);
      #1;
      check("e_in_ready", 16'(in_ready), 16'd0);
      tick();
      check("e_hold_valid", 16'(out_valid), 16'd1);
      check("e_hold_data",  16'(out_data),  16'd3);
    end
    clear_flags = 1'b0;
    check("e_sticky_cleared", 16'(sticky_sat), 16'd0);
    enable = 1'b1;
    reset  = 1'b1;
    #1;
    check("e_rst_in_ready", 16'(in_ready), 16'd0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("e_rst_out_valid", 16'(out_valid), 16'd0);
    check("e_rst_sticky",    16'({sticky_sat, sticky_nan}), 16'd0);
    check("e_rst_in_ready1", 16'(in_ready),  16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
